// File: rtl/rle_run_packer.sv
// Buffers RLE run records and end-of-image markers as 16-bit words, then
// serialises them MSB byte first on a valid/ready byte stream.
// Optional: define RLE_PACK_CHECKSUM_EN to append a per-frame XOR checksum after each marker.
module rle_run_packer #(
   parameter int LEN_W = 11,
   parameter int DEPTH = 64,
   parameter int CNT_W = 15
) (
   input  logic                       CLK,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic                       run_valid,
   input  logic [LEN_W-1:0]           run_len,
   input  logic                       run_colour,
   input  logic                       im_end,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [7:0]                 out_byte,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow,
   output logic [CNT_W-1:0]           frame_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HI    = 3'd1,
      S_LO    = 3'd2
`ifdef RLE_PACK_CHECKSUM_EN
      , S_CK_HI = 3'd3,
      S_CK_LO = 3'd4
`endif
   } state_t;

   // FIFO storage and bookkeeping
   logic [15:0]      r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;

   // write-side control
   logic             r_marker_pend;
   logic             r_overflow;
   logic [CNT_W-1:0] r_frame_count;

   // serialiser
   state_t           r_state;
   state_t           w_state_nxt;
   logic [15:0]      r_sh_reg;

   logic             w_full;
   logic             w_empty;
   logic             w_run_in;
   logic             w_mark_in;
   logic             w_write_marker;
   logic             w_write_run;
   logic             w_drop_run;
   logic             w_wr_en;
   logic [15:0]      w_wr_data;
   logic [15:0]      w_rd_data;
   logic [13:0]      w_len_ext;
   logic [15:0]      w_data_word;
   logic [15:0]      w_marker_word;
   logic             w_pop;

   assign w_full    = (r_level == LW'(DEPTH));
   assign w_empty   = (r_level == '0);
   assign w_run_in  = enable && run_valid;
   assign w_mark_in = enable && im_end;

   assign w_len_ext     = 14'(run_len);
   assign w_data_word   = {1'b0, run_colour, w_len_ext};
   assign w_marker_word = {1'b1, r_frame_count};

   // A pending marker owns the write port; any run that cannot be written
   // in a cycle is a lost record and is flagged as overflow.
   assign w_write_marker = r_marker_pend && !w_full;
   assign w_write_run    = w_run_in && !w_full && !r_marker_pend;
   assign w_drop_run     = w_run_in && !w_write_run;
   assign w_wr_en        = w_write_marker || w_write_run;
   assign w_wr_data      = w_write_marker ? w_marker_word : w_data_word;

   assign w_rd_data = r_mem[r_rd_ptr];

   // NOTE: the word array carries no reset; pointers and level alone decide
   // which entries are meaningful, so clearing the storage buys nothing.
   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= w_wr_data;
      end
   end

   // NOTE: every clocked block uses non-blocking assignments so all
   // registers update from the same pre-edge values.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr_en, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_marker_pend <= 1'b0;
         r_overflow    <= 1'b0;
         r_frame_count <= '0;
      end else begin
         if (w_write_marker) begin
            r_marker_pend <= 1'b0;
            r_frame_count <= r_frame_count + CNT_W'(1);
         end
         if (w_drop_run) begin
            r_overflow <= 1'b1;
         end
         // a new end-of-image wins over the marker being retired this cycle
         if (w_mark_in) begin
            r_marker_pend <= 1'b1;
         end
      end
   end

`ifdef RLE_PACK_CHECKSUM_EN
   logic [15:0] r_ck;
   logic [15:0] w_ck_base;
   logic        w_ck_clear;

   assign w_ck_clear = (r_state == S_CK_LO) && out_ready;
   assign w_ck_base  = w_ck_clear ? 16'h0000 : r_ck;

   // only data words contribute; a data word loaded as the checksum retires
   // becomes the first term of the next frame
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_ck <= '0;
      end else if (w_pop && !w_rd_data[15]) begin
         r_ck <= w_ck_base ^ w_rd_data;
      end else begin
         r_ck <= w_ck_base;
      end
   end
`endif

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_sh_reg <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) begin
            r_sh_reg <= w_rd_data;
         end
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      out_valid   = 1'b0;
      out_byte    = 8'h00;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_HI;
            end
         end
         S_HI: begin
            out_valid = 1'b1;
            out_byte  = r_sh_reg[15:8];
            if (out_ready) begin
               w_state_nxt = S_LO;
            end
         end
         S_LO: begin
            out_valid = 1'b1;
            out_byte  = r_sh_reg[7:0];
            if (out_ready) begin
`ifdef RLE_PACK_CHECKSUM_EN
               if (r_sh_reg[15]) begin
                  w_state_nxt = S_CK_HI;
               end else
`endif
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_HI;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
`ifdef RLE_PACK_CHECKSUM_EN
         S_CK_HI: begin
            out_valid = 1'b1;
            out_byte  = r_ck[15:8];
            if (out_ready) begin
               w_state_nxt = S_CK_LO;
            end
         end
         S_CK_LO: begin
            out_valid = 1'b1;
            out_byte  = r_ck[7:0];
            if (out_ready) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = S_HI;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign fifo_level  = r_level;
   assign overflow    = r_overflow;
   assign frame_count = r_frame_count;

endmodule

// File: doc/rle_run_packer.md
Name: rle_run_packer

Overview:
- Downstream neighbour of the RLE run-length encoder.
- Accepts one run-length record per strobe plus an end-of-image pulse and buffers them as 16-bit words in a synchronous FIFO.
- Serialises the words MSB-byte-first onto an 8-bit valid/ready byte stream for the rover's UART/SPI link to the ESP32.
- Frame boundaries are marked in-band so the far end can resynchronise per image.

Parameters:
- LEN_W, 11, run-length width; legal range 1..14.
- DEPTH, 64, FIFO depth in 16-bit words; power of two, at least 4.
- CNT_W, 15, frame counter width; fixed at 15.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  when low, run_valid and im_end are ignored; serialiser keeps draining.
- run_valid  in  1  one-cycle strobe; run_len and run_colour are valid.
- run_len  in  LEN_W  length of the completed run.
- run_colour  in  1  pixel value of the run (1 = foreground).
- im_end  in  1  one-cycle end-of-image pulse.
- out_ready  in  1  downstream accepts out_byte this cycle.
- out_valid  out  1  out_byte holds a valid byte.
- out_byte  out  8  serial byte.
- fifo_level  out  $clog2(DEPTH)+1  words currently stored; excludes the word in the shift register.
- overflow  out  1  sticky; set when a record is dropped.
- frame_count  out  CNT_W  markers written since reset; wraps.

Behaviour:
- Reset is asynchronous and active-low. All outputs and state clear to 0: out_valid, out_byte, fifo_level, overflow, frame_count, FIFO pointers, marker_pend, FSM in IDLE.
- Data word: {1'b0, run_colour, run_len zero-extended to 14 bits}.
- Marker word: {1'b1, frame_count} using the pre-increment value. frame_count increments when the marker is written.
- Write rules, one FIFO write per cycle at most, priority order:
  1. If marker_pend and FIFO not full: write the marker and clear marker_pend.
  2. Else if enable and run_valid: if FIFO full or marker_pend, drop the run and set overflow; otherwise write the data word.
  3. If enable and im_end: set marker_pend. im_end never writes directly.
- run_valid and im_end in the same cycle: the run is written that cycle and the marker on the next free cycle. Order is preserved.
- The marker is never dropped; it stays pending until space exists.
- Write and pop in the same cycle: fifo_level is unchanged. A pop from a full FIFO frees space only from the next cycle.
- Serialiser FSM:
  - IDLE: if FIFO not empty, pop into sh_reg and go to HI.
  - HI: out_valid=1, out_byte=sh_reg[15:8]. On out_ready go to LO.
  - LO: out_byte=sh_reg[7:0]. On out_ready, pop and go to HI if FIFO not empty, else go to IDLE.
- out_byte and out_valid are held stable while out_valid && !out_ready.
- Latency: with the block idle and empty, run_valid at edge N gives out_valid high after edge N+2. Back-to-back words have no bubble when out_ready is held high.
- Pointers wrap modulo DEPTH. fifo_level saturates at DEPTH (full) and 0 (empty).
- overflow clears only on reset.

Optional Feature:
- RLE_PACK_CHECKSUM_EN defined:
  - The serialiser keeps a 16-bit XOR of every data word as it is loaded into sh_reg.
  - After the LO byte of a marker word is accepted, it enters CK_HI then CK_LO, emitting the checksum MSB first under the same handshake.
  - The accumulator then clears to 0. The checksum is not stored in the FIFO and not counted in fifo_level.
- Undefined: no CK states; the byte stream contains data and marker words only.

Test Plan:
- Reset then run_valid with run_len=11'd300, colour=1, out_ready=1 -> bytes 8'h41, 8'h2C; out_valid first high 2 cycles after the strobe.
- run_valid (len=5, colour=0) and im_end in the same cycle, frame_count=0 -> bytes 00 05 80 00; frame_count=1.
- out_ready low for 10 cycles with HI pending -> out_byte stays at the HI value, out_valid stays 1, no byte lost after out_ready rises.
- 70 runs with out_ready=0, DEPTH=64 -> fifo_level=64, overflow=1, exactly 64 data words (plus the one in sh_reg) appear in order once drained.
- FIFO full, then im_end -> marker written on the first cycle after a pop; following runs dropped while pending; overflow set.
- With RLE_PACK_CHECKSUM_EN: runs 16'h0003 and 16'h4005 then im_end -> bytes 00 03 40 05 80 00 40 06, then the next frame's checksum starts from 0.
